rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Parameterised N-channel registered multiplexer. Arbitrates among CHANNELS valid/ready
//  input streams and forwards one WIDTH-bit word per cycle to a single registered output.
//  Arbitration is round-robin or fixed-priority, selected at runtime.
//  Sits between multiple producer blocks and one shared consumer: bus, UART TX or display driver.
// PARAMETERS
//  WIDTH     4  data width per channel (>=1)
//  CHANNELS  4  number of input channels (>=2, need not be a power of two)
//  SEL_W     localparam = (CHANNELS>1) ? $clog2(CHANNELS) : 1; width of channel index
// PORTS
//  clk        in   1               single clock, rising edge
//  reset      in   1               asynchronous, active-high; clears all state immediately
//  mode       in   1               0 = round-robin, 1 = fixed priority (lowest index wins)
//  in_data    in   CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel request
//  in_ready   out  CHANNELS        one-hot grant; word k transfers when in_valid[k] & in_ready[k]
//  out_data   out  WIDTH           registered selected word
//  out_chan   out  SEL_W           registered index of the channel that supplied out_data
//  out_valid  out  1               output word present
//  out_ready  in   1               consumer accepts when out_valid & out_ready
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_data=0, out_chan=0, RR pointer ptr=0.
//    While reset is high, in_ready=0.
//  - load_ok = !out_valid | out_ready. in_ready is combinational:
//    at most one bit set, only when load_ok and a request exists.
//  - Grant g in mode 0: first k with in_valid[k] set, searching cyclically from ptr.
//  - Grant g in mode 1: lowest k with in_valid[k] set.
//  - Edge with load_ok & |in_valid: out_data<=in_data[g], out_chan<=g, out_valid<=1.
//    In mode 0, ptr<=(g==CHANNELS-1)?0:g+1. In mode 1, ptr is unchanged.
//  - Edge with load_ok & !|in_valid: out_valid<=0. out_data and out_chan hold their values.
//  - Edge with !load_ok: all registers hold. out_data and out_chan stay stable under backpressure.
//  - Latency: 1 cycle from input handshake to out_valid.
//    Throughput: 1 word/cycle with out_ready=1 (no bubble).
//  - Simultaneous drain and load in one cycle is legal and required (load_ok covers it).
//  - ptr wraps at CHANNELS-1 for any CHANNELS. Indices >= CHANNELS are never granted.
//  - A mode change takes effect at the next grant. The word in flight is unaffected.
//  - Reset asserted mid-transfer: out_valid drops asynchronously. The pending word is discarded.
//  - in_valid deasserted by a producer without a grant is legal (no stickiness required).
// STRUCTURE
//  - Shared header mux_defs.vh: MODE_RR=1'b0, MODE_FIXED=1'b1.
//  - Sub-module rr_arbiter (combinational): inputs req[CHANNELS], ptr[SEL_W], mode.
//    Outputs grant_oh[CHANNELS], grant_idx[SEL_W], any.
//    Implement with a double-width rotate-and-priority search.
//  - Top module holds the output register, ptr register and load_ok logic.
// TESTING (WIDTH=4, CHANNELS=4, ch0..3 data 0,5,10,15 unless noted)
//  1. Reset pulse mid-stream while out_valid=1
//     -> out_valid=0 and out_chan=0 before the next clk edge; in_ready=0 while reset is high.
//  2. mode=0, in_valid=1111, out_ready=1
//     -> out_chan 0,1,2,3,0 and out_data 0,5,10,15,0 on consecutive cycles;
//        first out_valid 1 cycle after reset release.
//  3. As test 2, with out_ready=0 for 3 cycles at out_chan=1
//     -> out_data holds 5, in_ready=0000; after release, next word is ch2 (10).
//  4. mode=1, in_valid=1010 held -> every word from ch1 (5), ch3 never granted.
//     Switch to mode=0 -> ch3 and ch1 alternate.
//  5. mode=0, only ch3 valid for one transfer, then only ch0
//     -> ptr wraps 3->0; ch0 granted next cycle, out_data=0. No requests -> out_valid drops to 0.
//  6. CHANNELS=3, WIDTH=8, all valid -> out_chan cycles 0,1,2,0; index 3 never appears;
//     one-hot in_ready checked every cycle.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority output multiplexer.
package rr_mux_arbiter_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_arbiter.sv
// Combinational grant search: the request vector is doubled and shifted down by the
// search base, so the first set bit in the low half is the next requester in cyclic order.
module rr_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  input  logic                i_mode,
  output logic [CHANNELS-1:0] o_grant_oh,
  output logic [SEL_W-1:0]    o_grant_idx,
  output logic                o_any
);

  logic [SEL_W-1:0]      w_base;
  logic [2*CHANNELS-1:0] w_dbl;
  int                    w_off;
  int                    w_sum;

  always_comb begin
    w_base = (i_mode == MODE_FIXED) ? '0 : i_ptr;
    w_dbl  = {i_req, i_req} >> w_base;
    w_off  = 0;
    // Descending scan leaves the lowest set offset; the low half always holds every
    // request once, so a hit is found there whenever any request exists.
    for (int i = 2*CHANNELS-1; i >= 0; i--) begin
      if (w_dbl[i]) w_off = i;
    end
    w_sum = int'(w_base) + w_off;
    if (w_sum >= CHANNELS) w_sum = w_sum - CHANNELS;
    o_any       = |i_req;
    o_grant_idx = SEL_W'(w_sum);
    o_grant_oh  = o_any ? (CHANNELS'(1) << o_grant_idx) : '0;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready multiplexer with a single registered output stage and
// runtime-selectable round-robin or fixed-priority arbitration.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_mode,
  input  logic [CHANNELS*WIDTH-1:0] i_in_data,
  input  logic [CHANNELS-1:0]       i_in_valid,
  output logic [CHANNELS-1:0]       o_in_ready,
  output logic [WIDTH-1:0]          o_out_data,
  output logic [SEL_W-1:0]          o_out_chan,
  output logic                      o_out_valid,
  input  logic                      i_out_ready
);

  logic [SEL_W-1:0]    r_ptr;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic                r_valid;

  logic                w_load_ok;
  logic [CHANNELS-1:0] w_grant_oh;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_any;
  logic [WIDTH-1:0]    w_sel_data;
  logic [SEL_W-1:0]    w_ptr_next;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .i_req       (i_in_valid),
    .i_ptr       (r_ptr),
    .i_mode      (i_mode),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // The output slot is free when empty or when its word leaves this cycle.
  assign w_load_ok  = !r_valid || i_out_ready;
  assign o_in_ready = (w_load_ok && !i_reset) ? w_grant_oh : '0;

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (k == int'(w_grant_idx)) w_sel_data = i_in_data[k*WIDTH +: WIDTH];
    end
    w_ptr_next = (w_grant_idx == SEL_W'(CHANNELS-1)) ? '0 : w_grant_idx + SEL_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
    end else if (w_load_ok) begin
      if (w_any) begin
        r_data  <= w_sel_data;
        r_chan  <= w_grant_idx;
        r_valid <= 1'b1;
        if (i_mode == MODE_RR) r_ptr <= w_ptr_next;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_chan  = r_chan;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and randomized checks of rr_mux_arbiter against a cyclic-search reference model.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic        a_mode;
  logic [15:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [3:0]  a_out_data;
  logic [1:0]  a_out_chan;
  logic        a_out_valid;
  logic        a_out_ready;

  logic        b_mode;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_chan;
  logic        b_out_valid;
  logic        b_out_ready;

  int n_pass  = 0;
  int n_total = 0;
  int m_valid, m_data, m_chan, m_ptr;

  rr_mux_arbiter #(.WIDTH(4), .CHANNELS(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_mode(a_mode), .i_in_data(a_in_data),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .o_out_data(a_out_data),
    .o_out_chan(a_out_chan), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready)
  );

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_mode(b_mode), .i_in_data(b_in_data),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .o_out_data(b_out_data),
    .o_out_chan(b_out_chan), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Next requester: lowest index in fixed mode, otherwise first one found walking from ptr.
  function automatic int ref_grant(input logic [3:0] v, input logic md, input int p);
    if (v == 4'b0000) return -1;
    if (md) begin
      for (int i = 0; i < 4; i++) if (v[i]) return i;
    end
    for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
  endtask

  // Called just after a rising edge; checks in_ready mid-cycle, then outputs after the edge.
  task automatic cycle_a();
    int g;
    bit load_ok;
    logic [3:0] exp_rdy;
    g       = ref_grant(a_in_valid, a_mode, m_ptr);
    load_ok = (m_valid == 0) || a_out_ready;
    exp_rdy = (load_ok && g >= 0) ? 4'(1 << g) : 4'b0000;
    #4;
    chk("in_ready", {28'd0, a_in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (load_ok) begin
      if (g >= 0) begin
        m_data  = int'(a_in_data[g*4 +: 4]);
        m_chan  = g;
        m_valid = 1;
        if (!a_mode) m_ptr = (g + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", {31'd0, a_out_valid}, 32'(m_valid));
    chk("out_data",  {28'd0, a_out_data},  32'(m_data));
    chk("out_chan",  {30'd0, a_out_chan},  32'(m_chan));
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    a_mode = 1'b0; a_in_data = {4'd15, 4'd10, 4'd5, 4'd0}; a_in_valid = 4'b1111; a_out_ready = 1'b1;
    b_mode = 1'b0; b_in_data = {8'hA2, 8'hA1, 8'hA0}; b_in_valid = 3'b000; b_out_ready = 1'b1;
    model_reset();
    #2;
    chk("rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_data",  {28'd0, a_out_data},  32'd0);
    chk("rst_chan",  {30'd0, a_out_chan},  32'd0);
    chk("rst_ready", {28'd0, a_in_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin over all four channels, no backpressure.
    repeat (5) cycle_a();

    // Backpressure while channel 1's word sits in the output register.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle_a();
      if (m_valid == 1 && m_chan == 1) found = 1;
    end
    chk("seek_ch1", 32'(found), 32'd1);
    a_out_ready = 1'b0;
    repeat (3) cycle_a();
    a_out_ready = 1'b1;
    repeat (2) cycle_a();

    // Asynchronous reset while a word is valid.
    chk("pre_rst_valid", {31'd0, a_out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, a_out_valid}, 32'd0);
    chk("async_chan",  {30'd0, a_out_chan},  32'd0);
    chk("async_ready", {28'd0, a_in_ready},  32'd0);
    model_reset();
    @(posedge clk); #1;
    chk("held_ready", {28'd0, a_in_ready}, 32'd0);
    rst = 1'b0;
    repeat (2) cycle_a();

    // Fixed priority starves channel 3, then round-robin alternates.
    a_mode = 1'b1; a_in_valid = 4'b1010;
    repeat (4) cycle_a();
    a_mode = 1'b0;
    repeat (4) cycle_a();

    // Pointer wrap from channel 3 to channel 0, then idle.
    a_in_valid = 4'b1000; cycle_a();
    a_in_valid = 4'b0001; cycle_a();
    a_in_valid = 4'b0000; repeat (2) cycle_a();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      a_mode      = ($urandom_range(0, 7) == 0);
      a_in_valid  = 4'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_in_data   = 16'($urandom);
      cycle_a();
    end

    // Three-channel, 8-bit instance: strict 0,1,2 rotation and one-hot grant.
    a_in_valid = 4'b0000;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    b_in_valid = 3'b111;
    for (int i = 0; i < 9; i++) begin
      #4;
      chk("b_in_ready", {29'd0, b_in_ready}, 32'(1 << (i % 3)));
      @(posedge clk); #1;
      chk("b_out_chan",  {30'd0, b_out_chan}, 32'(i % 3));
      chk("b_out_data",  {24'd0, b_out_data}, 32'(8'hA0 + (i % 3)));
      chk("b_out_valid", {31'd0, b_out_valid}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
